jt900h_divsgn: RTL and testbench
================================

JT900H_DIVSGN -- requirements
Module: jt900h_divsgn

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  reset; synchronous and active-low.
REQ-003 SHALL have port: cen  in  1  clock enable; state advances only when high.
REQ-004 SHALL have ports: req in 1 (division request pulse); sgn in 1 (1=DIVS, 0=DIV); len in 2 (0=byte, 1=word, 2/3 reserved).
REQ-005 SHALL have ports: dvd in 16 (dividend); dvs in 16 (divisor; low 8 bits used in byte mode).
REQ-006 SHALL have divider-side ports: div_op0 out 16, div_op1 out 16, div_len out 2, div_start out 1, div_quot in 16, div_rem in 16, div_busy in 1.
REQ-007 SHALL have result ports: quot out 16, rem out 16, v out 1 (overflow/divide-by-zero), done out 1 (one-cycle pulse), busy out 1.

Function
REQ-008 SHALL implement FSM IDLE -> START -> WAIT -> FIX -> DONE -> IDLE; transitions only on cycles with cen=1.
REQ-009 SHALL accept req only in IDLE; req in any other state SHALL be ignored with no queueing.
REQ-010 SHALL latch sgn, len, dvd, dvs and dividend/divisor signs on acceptance; busy SHALL be high from the next cycle until DONE exits.
REQ-011 SHALL, in START, drive div_op0/div_op1 with operand magnitudes (two's-complement negated if sgn and negative) and assert div_start for exactly one cen cycle; div_len SHALL equal latched len.
REQ-012 SHALL, in WAIT, leave only after div_busy has been seen high and then low; a missing busy rise SHALL NOT be treated as completion.
REQ-013 SHALL, in FIX, negate quotient when operand signs differ and give remainder the dividend's sign (signed mode only).
REQ-014 SHALL set v=1 when quotient magnitude exceeds the result width: unsigned byte >255, word >65535 (n/a); signed byte >127 positive or >128 negative, word >32767/32768.
REQ-015 SHALL bypass the divider when divisor (width-masked) is zero: IDLE -> DONE via FIX in two cycles, v=1, quot = all ones in width, rem = dividend low width.
REQ-016 SHALL treat len=2/3 as divide-by-zero behaviour (v=1) without starting the divider.
REQ-017 SHALL pulse done for one cen cycle in DONE with quot/rem/v valid; quot/rem/v SHALL hold until next acceptance.
REQ-018 SHALL zero-extend byte-mode quot/rem into 16 bits (upper byte 0).

Reset
REQ-019 SHALL, on rst=0 at a clock edge, force IDLE, quot=0, rem=0, v=0, done=0, busy=0, div_start=0, div_op0=0, div_op1=0, div_len=0, regardless of cen.
REQ-020 SHALL abandon any in-flight division on reset; late div_busy falling SHALL NOT produce done.

Configuration
REQ-021 SHALL, with JT900H_DIVS_EN defined, support signed division per REQ-011/013/014.
REQ-022 SHALL, without JT900H_DIVS_EN, ignore sgn, omit sign/negation logic, and behave as unsigned DIV for all requests.

Structure
REQ-023 SHALL take FSM state encoding and len encodings (LEN_BYTE, LEN_WORD) from shared package jt900h_pkg.
REQ-024 SHALL use one sub-module jt900h_divsgn_abs (width-parametric conditional negate) for operand magnitude and result sign fix.

Verification
REQ-025 Unsigned byte: dvd=0x0064, dvs=0x07, sgn=0 -> div_start once, done with quot=0x000E, rem=0x0002, v=0.
REQ-026 Signed byte: dvd=0xFF9C (-100), dvs=0x07, sgn=1 -> div_op0=0x0064; quot=0x00F2 (-14), rem=0x00FE (-2), v=0.
REQ-027 Divide by zero: len=1, dvd=0x1234, dvs=0 -> no div_start, done 2 cycles after req, quot=0xFFFF, rem=0x1234, v=1.
REQ-028 Overflow: len=0, dvd=0x1000, dvs=0x02, sgn=0 -> quot low byte don't-care, v=1.
REQ-029 Second req during WAIT plus cen toggling -> ignored, single done, results unchanged by second req.
REQ-030 rst=0 asserted in WAIT -> all outputs zero next edge, no done even when div_busy later falls.

Source files
------------

// File: rtl/jt900h_pkg.sv
// jt900h_pkg: shared FSM state encoding, operand length codes and width-fit helper
package jt900h_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT, ST_FIX, ST_DONE} st_t;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_WORD = 2'd1;

    // Byte results live in the low byte with the upper byte cleared
    function automatic logic [15:0] fit(input logic [15:0] x, input logic bw);
        return bw ? {8'd0, x[7:0]} : x;
    endfunction

endpackage

// File: rtl/jt900h_divsgn_abs.sv
// jt900h_divsgn_abs: width-parametric conditional two's-complement negate
module jt900h_divsgn_abs #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? -a : a;

endmodule

// File: rtl/jt900h_divsgn.sv
// jt900h_divsgn: DIV/DIVS sequencer around an external unsigned divider.
// Signed (DIVS) support is compiled in only when JT900H_DIVS_EN is defined.
module jt900h_divsgn
    import jt900h_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        req,
    input  logic        sgn,
    input  logic [1:0]  len,
    input  logic [15:0] dvd,
    input  logic [15:0] dvs,
    output logic [15:0] div_op0,
    output logic [15:0] div_op1,
    output logic [1:0]  div_len,
    output logic        div_start,
    input  logic [15:0] div_quot,
    input  logic [15:0] div_rem,
    input  logic        div_busy,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic        v,
    output logic        done,
    output logic        busy
);

    st_t         st_q, st_d;
    logic [15:0] op0_q, op0_d, op1_q, op1_d, dvd_q, dvd_d, quot_q, quot_d, rem_q, rem_d;
    logic [1:0]  len_q, len_d;
    logic        v_q, v_d, z_q, z_d, seen_q, seen_d, sg_q, sg_d, nq_q, nq_d, nr_q, nr_d;

    logic        byte_in, zero_in, bw, sg_in, nq_in, nr_in;
    logic [15:0] dvs_w, dvd_mag, dvs_neg, q_fix, r_fix, lim;

    assign byte_in = len == LEN_BYTE;
    assign dvs_w   = fit(dvs, byte_in);
    // Reserved lengths share the divide-by-zero path so the divider never sees them
    assign zero_in = (len != LEN_BYTE && len != LEN_WORD) || dvs_w == 16'd0;
    assign bw      = len_q == LEN_BYTE;

`ifdef JT900H_DIVS_EN
    logic sd, ss;
    assign sg_in = sgn;
    assign sd    = sgn & dvd[15];
    assign ss    = sgn & (byte_in ? dvs[7] : dvs[15]);
    assign nq_in = sd ^ ss;
    assign nr_in = sd;
    jt900h_divsgn_abs #(.W(16)) u_dvd  (.a(dvd),      .neg(sd),   .y(dvd_mag));
    jt900h_divsgn_abs #(.W(16)) u_dvs  (.a(dvs_w),    .neg(ss),   .y(dvs_neg));
    jt900h_divsgn_abs #(.W(16)) u_quot (.a(div_quot), .neg(nq_q), .y(q_fix));
    jt900h_divsgn_abs #(.W(16)) u_rem  (.a(div_rem),  .neg(nr_q), .y(r_fix));
`else
    logic [1:0] unused_sgn;
    assign unused_sgn = {sgn, nr_q};
    assign sg_in   = 1'b0;
    assign nq_in   = 1'b0;
    assign nr_in   = 1'b0;
    assign dvd_mag = dvd;
    assign dvs_neg = dvs_w;
    assign q_fix   = div_quot;
    assign r_fix   = div_rem;
`endif

    // Largest quotient magnitude representable in the result width
    assign lim = bw ? (nq_q ? 16'd128 : sg_q ? 16'd127 : 16'd255)
                    : (nq_q ? 16'h8000 : sg_q ? 16'h7FFF : 16'hFFFF);

    always_comb begin
        st_d   = st_q;
        op0_d  = op0_q;
        op1_d  = op1_q;
        dvd_d  = dvd_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        len_d  = len_q;
        v_d    = v_q;
        z_d    = z_q;
        seen_d = seen_q;
        sg_d   = sg_q;
        nq_d   = nq_q;
        nr_d   = nr_q;
        case (st_q)
            ST_IDLE: if (req) begin
                op0_d  = dvd_mag;
                op1_d  = fit(dvs_neg, byte_in);
                dvd_d  = dvd;
                len_d  = len;
                z_d    = zero_in;
                sg_d   = sg_in;
                nq_d   = nq_in;
                nr_d   = nr_in;
                seen_d = 1'b0;
                st_d   = zero_in ? ST_FIX : ST_START;
            end
            ST_START: st_d = ST_WAIT;
            ST_WAIT: begin
                seen_d = seen_q | div_busy;
                st_d   = (seen_q && !div_busy) ? ST_FIX : ST_WAIT;
            end
            ST_FIX: begin
                quot_d = fit(z_q ? 16'hFFFF : q_fix, bw);
                rem_d  = fit(z_q ? dvd_q : r_fix, bw);
                v_d    = z_q || div_quot > lim;
                st_d   = ST_DONE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= ST_IDLE;
            op0_q  <= '0;
            op1_q  <= '0;
            dvd_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            len_q  <= '0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
            seen_q <= 1'b0;
            sg_q   <= 1'b0;
            nq_q   <= 1'b0;
            nr_q   <= 1'b0;
        end else if (cen) begin
            st_q   <= st_d;
            op0_q  <= op0_d;
            op1_q  <= op1_d;
            dvd_q  <= dvd_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            len_q  <= len_d;
            v_q    <= v_d;
            z_q    <= z_d;
            seen_q <= seen_d;
            sg_q   <= sg_d;
            nq_q   <= nq_d;
            nr_q   <= nr_d;
        end
    end

    assign div_op0   = op0_q;
    assign div_op1   = op1_q;
    assign div_len   = len_q;
    assign div_start = st_q == ST_START;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign v         = v_q;
    assign done      = st_q == ST_DONE;
    assign busy      = st_q != ST_IDLE;

endmodule

// File: tb/tb_jt900h_divsgn.sv
// tb_jt900h_divsgn: directed self-checking bench; the bench plays the external divider
module tb_jt900h_divsgn;

    logic        clk = 1'b0, rst = 1'b0, cen = 1'b1, req = 1'b0, sgn = 1'b0;
    logic [1:0]  len = 2'd0;
    logic [15:0] dvd = '0, dvs = '0, div_quot = '0, div_rem = '0;
    logic        div_busy = 1'b0;
    logic [15:0] div_op0, div_op1, quot, rem;
    logic [1:0]  div_len;
    logic        div_start, v, done, busy;
    int          checks = 0, failures = 0, starts = 0, dones = 0;
    bit          tog = 1'b0;

    jt900h_divsgn dut (
        .clk(clk), .rst(rst), .cen(cen), .req(req), .sgn(sgn), .len(len),
        .dvd(dvd), .dvs(dvs), .div_op0(div_op0), .div_op1(div_op1),
        .div_len(div_len), .div_start(div_start), .div_quot(div_quot),
        .div_rem(div_rem), .div_busy(div_busy), .quot(quot), .rem(rem),
        .v(v), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst && cen) begin
        if (div_start) starts++;
        if (done) dones++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
        if (tog) cen = ~cen;
    endtask

    task automatic issue(input logic s, input logic [1:0] l, input logic [15:0] a, input logic [15:0] b);
        sgn = s; len = l; dvd = a; dvs = b; req = 1'b1;
        tick;
        req = 1'b0;
    endtask

    task automatic divide(input logic [15:0] q, input logic [15:0] r);
        div_busy = 1'b1;
        repeat (4) tick;
        div_quot = q; div_rem = r; div_busy = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin ok = 1'b1; break; end
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; cen = 1'b0;
        tick; tick;
        checks++;
        if ({quot, rem, v, done, busy, div_start, div_op0, div_op1, div_len} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {quot, rem, v, done, busy, div_start, div_op0, div_op1, div_len});
        end
        rst = 1'b1; cen = 1'b1;
        tick;
    endtask

    task automatic test_unsigned_byte;
        int s0 = starts;
        bit ok;
        issue(1'b0, 2'd0, 16'h0064, 16'h0007);
        checks++;
        if ({div_start, busy, div_op0, div_op1, div_len} !== {1'b1, 1'b1, 16'h0064, 16'h0007, 2'd0}) begin
            failures++;
            $display("FAIL ubyte_start got=%h exp=%h", {div_start, busy, div_op0, div_op1, div_len}, {1'b1, 1'b1, 16'h0064, 16'h0007, 2'd0});
        end
        divide(16'd14, 16'd2);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ubyte_done_timeout got=0 exp=1"); end
        checks++;
        if ({quot, rem, v} !== {16'h000E, 16'h0002, 1'b0}) begin
            failures++;
            $display("FAIL ubyte_result got=%h/%h/%b exp=000e/0002/0", quot, rem, v);
        end
        checks++;
        if (starts - s0 != 1) begin failures++; $display("FAIL ubyte_starts got=%0d exp=1", starts - s0); end
        tick;
        checks++;
        if ({done, busy, quot} !== {1'b0, 1'b0, 16'h000E}) begin
            failures++;
            $display("FAIL ubyte_after got=%b%b/%h exp=00/000e", done, busy, quot);
        end
    endtask

    task automatic test_signed_byte;
        bit ok;
        issue(1'b1, 2'd0, 16'hFF9C, 16'h0007);
`ifdef JT900H_DIVS_EN
        checks++;
        if ({div_op0, div_op1} !== {16'h0064, 16'h0007}) begin
            failures++;
            $display("FAIL sbyte_ops got=%h/%h exp=0064/0007", div_op0, div_op1);
        end
        divide(16'd14, 16'd2);
        wait_done(ok);
        checks++;
        if (!ok || {quot, rem, v} !== {16'h00F2, 16'h00FE, 1'b0}) begin
            failures++;
            $display("FAIL sbyte_result got=%h/%h/%b exp=00f2/00fe/0", quot, rem, v);
        end
`else
        checks++;
        if ({div_op0, div_op1} !== {16'hFF9C, 16'h0007}) begin
            failures++;
            $display("FAIL sgn_ignored_ops got=%h/%h exp=ff9c/0007", div_op0, div_op1);
        end
        divide(16'd9348, 16'd0);
        wait_done(ok);
        checks++;
        if (!ok || {quot, rem, v} !== {16'h0084, 16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL sgn_ignored_result got=%h/%h/%b exp=0084/0000/1", quot, rem, v);
        end
`endif
        tick;
    endtask

    task automatic test_div_zero;
        int s0 = starts;
        issue(1'b0, 2'd1, 16'h1234, 16'h0000);
        checks++;
        if ({done, div_start, busy} !== 3'b001) begin
            failures++;
            $display("FAIL dz_first got=%b exp=001", {done, div_start, busy});
        end
        tick;
        checks++;
        if ({done, quot, rem, v} !== {1'b1, 16'hFFFF, 16'h1234, 1'b1}) begin
            failures++;
            $display("FAIL dz_word got=%b/%h/%h/%b exp=1/ffff/1234/1", done, quot, rem, v);
        end
        tick;
        issue(1'b0, 2'd0, 16'h1234, 16'h0100);
        tick;
        checks++;
        if ({done, quot, rem, v} !== {1'b1, 16'h00FF, 16'h0034, 1'b1}) begin
            failures++;
            $display("FAIL dz_byte_masked got=%b/%h/%h/%b exp=1/00ff/0034/1", done, quot, rem, v);
        end
        tick;
        issue(1'b0, 2'd2, 16'h5678, 16'h0003);
        tick;
        checks++;
        if ({done, quot, rem, v} !== {1'b1, 16'hFFFF, 16'h5678, 1'b1}) begin
            failures++;
            $display("FAIL dz_len2 got=%b/%h/%h/%b exp=1/ffff/5678/1", done, quot, rem, v);
        end
        tick;
        checks++;
        if (starts != s0) begin failures++; $display("FAIL dz_no_start got=%0d exp=0", starts - s0); end
    endtask

    task automatic test_overflow;
        bit ok;
        issue(1'b0, 2'd0, 16'h1000, 16'h0002);
        divide(16'h0800, 16'h0000);
        wait_done(ok);
        checks++;
        if (!ok || v !== 1'b1) begin failures++; $display("FAIL ovf_byte got=%b exp=1", v); end
        tick;
        issue(1'b0, 2'd0, 16'h00FF, 16'h0001);
        divide(16'h00FF, 16'h0000);
        wait_done(ok);
        checks++;
        if (!ok || {quot, v} !== {16'h00FF, 1'b0}) begin
            failures++;
            $display("FAIL ovf_edge255 got=%h/%b exp=00ff/0", quot, v);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int s0 = starts, d0 = dones;
        bit ok;
        issue(1'b0, 2'd1, 16'h0100, 16'h0010);
        tog = 1'b1;
        sgn = 1'b0; len = 2'd1; dvd = 16'h0005; dvs = 16'h0000; req = 1'b1;
        divide(16'h0010, 16'h0000);
        req = 1'b0;
        wait_done(ok);
        tog = 1'b0; cen = 1'b1;
        repeat (4) tick;
        checks++;
        if (!ok || dones - d0 != 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", dones - d0); end
        checks++;
        if (starts - s0 != 1) begin failures++; $display("FAIL b2b_start_count got=%0d exp=1", starts - s0); end
        checks++;
        if ({quot, rem, v, busy} !== {16'h0010, 16'h0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_result got=%h/%h/%b/%b exp=0010/0000/0/0", quot, rem, v, busy);
        end
    endtask

    task automatic test_no_busy_rise;
        int d0 = dones;
        bit ok;
        issue(1'b0, 2'd1, 16'h0009, 16'h0003);
        repeat (10) tick;
        checks++;
        if (dones != d0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL nobusy_hold got=%0d/%b exp=0/1", dones - d0, busy);
        end
        divide(16'd3, 16'd0);
        wait_done(ok);
        checks++;
        if (!ok || quot !== 16'h0003) begin failures++; $display("FAIL nobusy_result got=%h exp=0003", quot); end
        tick;
    endtask

    task automatic test_reset_in_wait;
        int d0 = dones;
        issue(1'b0, 2'd1, 16'h0040, 16'h0004);
        div_busy = 1'b1;
        tick; tick;
        rst = 1'b0; cen = 1'b0;
        tick;
        checks++;
        if ({quot, rem, v, done, busy, div_start, div_op0, div_op1, div_len} !== '0) begin
            failures++;
            $display("FAIL rst_wait_outputs got=%h exp=0", {quot, rem, v, done, busy, div_start, div_op0, div_op1, div_len});
        end
        rst = 1'b1; cen = 1'b1;
        div_quot = 16'h0010; div_busy = 1'b0;
        repeat (6) tick;
        checks++;
        if (dones != d0 || {done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL rst_wait_no_done got=%0d/%b%b exp=0/00", dones - d0, done, busy);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_byte;
        test_signed_byte;
        test_div_zero;
        test_overflow;
        test_back_to_back;
        test_no_busy_rise;
        test_reset_in_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
